// File: rtl/puf_pkg.sv
// Shared types and helpers for the PUF key extractor.
// Default sizes match the 256-bit PUF generator.
package puf_pkg;

  localparam int DEF_WIDTH = 256;
  localparam int DEF_NUM_SAMPLES = 7;
  localparam int DEF_SETTLE_CYCLES = 4;

  typedef enum logic [2:0] {
    IDLE,
    ENABLE,
    SAMPLE,
    GAP,
    COMPUTE,
    VALID
  } state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Majority voting needs an odd sample count and a small counter.
  function automatic bit samples_ok(input int n);
    return (n % 2 == 1) && (n >= 3) && (n <= 15);
  endfunction

  function automatic bit settle_ok(input int n);
    return (n >= 1) && (n <= 255);
  endfunction

endpackage

// File: rtl/puf_key_extractor_voter.sv
// Per-bit temporal vote: counts ones across samples, reports the
// majority value and whether the bit ever disagreed.
module puf_bit_voter
  import puf_pkg::*;
#(
  parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
  parameter int CW = cnt_width(DEF_NUM_SAMPLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc_en,
  input  logic bit_in,
  output logic vote,
  output logic unstable
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc_en && bit_in) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign vote = cnt > CW'(NUM_SAMPLES / 2);
  assign unstable = (cnt != '0) && (cnt != CW'(NUM_SAMPLES));

endmodule

// File: rtl/puf_key_extractor.sv
// Sequences the PUF generator, samples it repeatedly and hands a
// majority-voted key plus stability mask downstream.
module puf_key_extractor
  import puf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       challenge,
  output logic             busy,
  output logic             puf_enable,
  output logic [1:0]       puf_control,
  input  logic [WIDTH-1:0] puf_response,
  output logic [WIDTH-1:0] key,
  output logic [WIDTH-1:0] unstable_mask,
  output logic [8:0]       unstable_count,
  output logic             key_valid,
  input  logic             key_ready
);

  localparam int CW = cnt_width(NUM_SAMPLES);
  localparam int SW = 8;

  if (!samples_ok(NUM_SAMPLES)) begin : g_bad_samples
    $error("NUM_SAMPLES must be odd and within 3..15");
  end
  if (!settle_ok(SETTLE_CYCLES)) begin : g_bad_settle
    $error("SETTLE_CYCLES must be within 1..255");
  end

  state_t state;
  logic [SW-1:0] settle;
  logic [CW-1:0] samples;
  logic [WIDTH-1:0] votes;
  logic [WIDTH-1:0] unstable;
  logic [8:0] pop;
  logic clr;
  logic inc_en;

  assign busy = state != IDLE;
  assign clr = (state == IDLE) && start;
  assign inc_en = state == SAMPLE;

  for (genvar i = 0; i < WIDTH; i++) begin : g_voter
    puf_bit_voter #(
      .NUM_SAMPLES(NUM_SAMPLES),
      .CW(CW)
    ) u_voter (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .inc_en(inc_en),
      .bit_in(puf_response[i]),
      .vote(votes[i]),
      .unstable(unstable[i])
    );
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + 9'(unstable[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      settle <= '0;
      samples <= '0;
      puf_enable <= 1'b0;
      puf_control <= '0;
      key <= '0;
      unstable_mask <= '0;
      unstable_count <= '0;
      key_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= ENABLE;
            puf_control <= challenge;
            puf_enable <= 1'b1;
            settle <= '0;
            samples <= '0;
          end
        end
        ENABLE: begin
          if (settle == SW'(SETTLE_CYCLES - 1)) begin
            state <= SAMPLE;
          end else begin
            settle <= settle + 1'b1;
          end
        end
        SAMPLE: begin
          samples <= samples + 1'b1;
          puf_enable <= 1'b0;
          state <= GAP;
        end
        GAP: begin
          if (samples < CW'(NUM_SAMPLES)) begin
            state <= ENABLE;
            puf_enable <= 1'b1;
            settle <= '0;
          end else begin
            state <= COMPUTE;
          end
        end
        COMPUTE: begin
          key <= votes;
          unstable_mask <= unstable;
          unstable_count <= pop;
          key_valid <= 1'b1;
          state <= VALID;
        end
        VALID: begin
          if (key_ready) begin
            key_valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_key_extractor.sv
// Directed bench for puf_key_extractor: table of response patterns
// plus hand sequences for handshake, reset and back-to-back runs.
module tb_puf_key_extractor;

  localparam int W = 256;
  localparam int N = 7;
  localparam int S = 4;
  localparam int LAT = N * (S + 2) + 1;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [1:0] challenge;
  logic busy;
  logic puf_enable;
  logic [1:0] puf_control;
  logic [W-1:0] puf_response;
  logic [W-1:0] key;
  logic [W-1:0] unstable_mask;
  logic [8:0] unstable_count;
  logic key_valid;
  logic key_ready;

  int passed = 0;
  int total = 0;

  logic [W-1:0] pat [N];

  int hi_cnt = 0;
  int lo_cnt = 0;
  int sidx = 0;
  int pulses = 0;
  int bad_pulse = 0;
  int bad_gap = 0;

  typedef struct {
    logic [1:0]   chal;
    logic [W-1:0] base;
    logic [W-1:0] fm_a;
    int           ka;
    logic [W-1:0] fm_b;
    int           kb;
    logic [W-1:0] ekey;
    logic [W-1:0] emask;
    logic [8:0]   ecnt;
    bit           hold;
  } vec_t;

  vec_t vt [6];

  puf_key_extractor dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .challenge(challenge),
    .busy(busy),
    .puf_enable(puf_enable),
    .puf_control(puf_control),
    .puf_response(puf_response),
    .key(key),
    .unstable_mask(unstable_mask),
    .unstable_count(unstable_count),
    .key_valid(key_valid),
    .key_ready(key_ready)
  );

  always #5 clk = ~clk;

  // Generator model: garbage on every cycle except the sample cycle
  // (the S+1-th high cycle); also tracks the enable waveform.
  always @(negedge clk) begin
    if (!busy) begin
      hi_cnt = 0;
      lo_cnt = 0;
      sidx = 0;
      pulses = 0;
      bad_pulse = 0;
      bad_gap = 0;
      puf_response = ~pat[0];
    end else if (puf_enable) begin
      if (hi_cnt == 0 && pulses > 0 && lo_cnt != 1) bad_gap++;
      hi_cnt++;
      lo_cnt = 0;
      if (hi_cnt == S + 1 && sidx < N) begin
        puf_response = pat[sidx];
        sidx++;
      end else begin
        puf_response = ~pat[(sidx < N) ? sidx : N - 1];
      end
    end else begin
      if (hi_cnt > 0) begin
        pulses++;
        if (hi_cnt != S + 1) bad_pulse++;
      end
      hi_cnt = 0;
      lo_cnt++;
      puf_response = ~pat[(sidx < N) ? sidx : N - 1];
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(
    input logic [1:0] chal, input logic [W-1:0] base,
    input logic [W-1:0] fm_a, input int ka,
    input logic [W-1:0] fm_b, input int kb,
    input logic [W-1:0] ekey, input logic [W-1:0] emask,
    input logic [8:0] ecnt, input bit hold);
    vec_t v;
    v.chal = chal;
    v.base = base;
    v.fm_a = fm_a;
    v.ka = ka;
    v.fm_b = fm_b;
    v.kb = kb;
    v.ekey = ekey;
    v.emask = emask;
    v.ecnt = ecnt;
    v.hold = hold;
    return v;
  endfunction

  task automatic run(input vec_t v, input string tag);
    int lat;
    bit ok;
    for (int j = 0; j < N; j++) begin
      pat[j] = v.base ^ ((j < v.ka) ? v.fm_a : {W{1'b0}})
                      ^ ((j < v.kb) ? v.fm_b : {W{1'b0}});
    end
    @(negedge clk);
    challenge = v.chal;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    challenge = ~v.chal;
    key_ready = 1'b1;
    lat = 0;
    while (!key_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 30) key_ready = 1'b0;
    end
    key_ready = 1'b0;
    chk({tag, "_latency"}, W'(lat), W'(LAT));
    chk({tag, "_key"}, key, v.ekey);
    chk({tag, "_mask"}, unstable_mask, v.emask);
    chk({tag, "_count"}, W'(unstable_count), W'(v.ecnt));
    chk({tag, "_control"}, W'(puf_control), W'(v.chal));
    chk({tag, "_pulses"}, W'(pulses), W'(N));
    chk({tag, "_wave"}, W'(bad_pulse + bad_gap), W'(0));
    if (v.hold) begin
      ok = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        start = (c == 3);
        @(posedge clk);
        #1;
        if (!(key_valid && busy && !puf_enable && key === v.ekey))
          ok = 1'b0;
      end
      start = 1'b0;
      chk({tag, "_hold"}, W'(ok), W'(1));
    end
    @(negedge clk);
    key_ready = 1'b1;
    @(posedge clk);
    #1;
    key_ready = 1'b0;
    chk({tag, "_idle"}, W'({key_valid, busy, puf_enable}), W'(0));
    chk({tag, "_key_held"}, key, v.ekey);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    challenge = 2'b00;
    key_ready = 1'b0;
    for (int j = 0; j < N; j++) pat[j] = '0;

    vt[0] = mk(2'b10, {32{8'hA5}}, '0, 0, '0, 0,
               {32{8'hA5}}, '0, 9'd0, 1'b1);
    vt[1] = mk(2'b01, {1'b1, 255'b0}, {255'b0, 1'b1}, 3,
               {1'b1, 255'b0}, 2, {1'b1, 255'b0},
               {1'b1, 254'b0, 1'b1}, 9'd2, 1'b0);
    vt[2] = mk(2'b11, {16{16'hF00F}}, 256'hFF, 1, '0, 0,
               {16{16'hF00F}}, 256'hFF, 9'd8, 1'b0);
    vt[3] = mk(2'b00, {64{4'h9}}, {W{1'b1}}, 4, '0, 0,
               {64{4'h6}}, {W{1'b1}}, 9'd256, 1'b0);
    vt[4] = mk(2'b10, {W{1'b1}}, '0, 0, '0, 0,
               {W{1'b1}}, '0, 9'd0, 1'b0);
    vt[5] = mk(2'b01, '0, 256'hF0, 3, 256'h0F, 4,
               256'h0F, 256'hFF, 9'd8, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_key", key, '0);
    chk("rst_mask", unstable_mask, '0);
    chk("rst_ctl", W'({key_valid, puf_enable, busy,
                       puf_control, unstable_count}), W'(0));
    @(negedge clk);
    key_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    key_ready = 1'b0;
    chk("ready_in_idle", W'({busy, key_valid}), W'(0));

    for (int i = 0; i < 6; i++) begin
      run(vt[i], $sformatf("v%0d", i));
    end

    for (int j = 0; j < N; j++) pat[j] = '1;
    @(negedge clk);
    challenge = 2'b10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3 * (S + 2) + S) @(posedge clk);
    #1;
    chk("abort_in_sample4", W'({puf_enable, 8'(pulses)}),
        W'({1'b1, 8'd3}));
    rst = 1'b1;
    #1;
    chk("abort_key", key, '0);
    chk("abort_mask", unstable_mask, '0);
    chk("abort_ctl", W'({key_valid, puf_enable, busy,
                         puf_control, unstable_count}), W'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run(mk(2'b11, '0, '0, 0, '0, 0, '0, '0, 9'd0, 1'b0), "fresh");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
